lru_matrix8: RTL and testbench
==============================

// Module: lru_matrix8
// PURPOSE
//  True-LRU tracker for an 8-entry fully-associative victim cache.
//  Keeps a triangular age matrix (one flop per way pair) and continuously outputs the least-recently-used way as a one-hot vector.
//  Cache controller pulses lru_update on a hit (touch way) or add_cache on a fill (touch current LRU = evict/replace).
// PARAMETERS
//  WAYS  8  number of tracked ways; matrix holds WAYS*(WAYS-1)/2 bits (must be >=2)
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     asynchronous, active-high; clears whole matrix
//  lru_update  in   WAYS  one-hot touch request; way i becomes most-recent; all-zero = idle
//  add_cache   in   1     fill/evict strobe; the current LRU way becomes most-recent
//  lru_number  out  WAYS  one-hot index of current LRU way; bit 0 = way 0; always exactly one bit set
// BEHAVIOUR
//  - State: bit A[r][c] for r>c; 1 = way c older than way r, 0 = way c newer than way r.
//  - Touch way k (synchronous, at posedge): A[k][j]=1 for all j<k (row set); A[r][k]=0 for all r>k (column clear); other bits hold.
//  - LRU decode (combinational from state): way k is LRU iff A[k][j]==0 for all j<k AND A[r][k]==1 for all r>k.
//  - Effective touch vector: add_cache ? lru_number : lru_update. add_cache has priority; lru_update ignored that cycle.
//  - Multiple lru_update bits set: lowest-index set bit wins, others ignored.
//  - Idle (add_cache=0, lru_update=0): state holds.
//  - Latency: touch at edge N; new lru_number valid after edge N (combinational output of state).
//  - Reset (async, any time, incl. mid-update): all A bits = 0 -> age order oldest..newest = 7,6,5,4,3,2,1,0; lru_number = 8'b1000_0000.
//  - Touching the already-newest way: no state change. Touching the LRU way via lru_update == add_cache.
//  - Matrix is always a consistent total order, so lru_number is always one-hot (never zero, never multi-hot).
// CONFIGURATION
//  LRU_IDX_OUT_EN defined: adds output lru_idx [$clog2(WAYS)-1:0] = binary encoding of lru_number (same timing, reset value WAYS-1).
//  LRU_IDX_OUT_EN undefined: port absent, no encoder logic; lru_number behaviour identical in both builds.
// STRUCTURE
//  - Shared package lru_pkg: LRU_WAYS=8 constant, typedef logic [LRU_WAYS-1:0] way_mask_t, function onehot_to_idx().
//  - Sub-module lru_age_cell: one matrix bit; inputs clk, reset, set, clr; async reset to 0; set/clr never both high by construction (row k vs column k are disjoint).
//  - Top: generate loop over r>c instantiating lru_age_cell; set = touch[r], clr = touch[c]; priority encoder on lru_update; add_cache select mux; LRU decode AND-trees.
// TESTING
//  1. Reset, idle 2 cycles -> lru_number=8'h80; all matrix bits 0.
//  2. After reset, add_cache x3 -> lru_number 8'h40, 8'h20, then 8'h10 (order 4,3,2,1,0,7,6,5).
//  3. From (2): update 8'h04, 8'h08, add_cache -> order 1,0,7,6,5,2,3,4; lru_number=8'h02.
//  4. From (3): update 8'h01, 8'h02, 8'h40, add_cache, add_cache -> order 2,3,4,0,1,6,7,5; lru_number=8'h04.
//  5. add_cache=1 with lru_update=8'h01 simultaneously -> only LRU way touched, way 0 age unchanged.
//  6. Assert reset mid-sequence between edges -> lru_number=8'h80 immediately, no clock needed; lru_number one-hot every cycle of random stimulus.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types and helpers for the 8-way true-LRU age matrix.
package lru_pkg;

   localparam int LRU_WAYS  = 8;
   localparam int LRU_IDX_W = $clog2(LRU_WAYS);

   typedef logic [LRU_WAYS-1:0] way_mask_t;

   function automatic logic [LRU_IDX_W-1:0] onehot_to_idx(
      input way_mask_t m
   );
      logic [LRU_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < LRU_WAYS; i++) begin
         if (m[i]) idx |= LRU_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lru_age_cell.sv
// One age-matrix bit: set when its row way is touched, cleared for its column way.
module lru_age_cell (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clr,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    q <= 1'b0;
      else if (set) q <= 1'b1;
      else if (clr) q <= 1'b0;
   end

endmodule

// File: rtl/lru_matrix8.sv
// True-LRU tracker for an 8-entry victim cache, one-hot LRU output.
// Define LRU_IDX_OUT_EN to add the binary lru_idx output.
module lru_matrix8
   import lru_pkg::*;
#(
   parameter int WAYS = LRU_WAYS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WAYS-1:0]         lru_update,
   input  logic                    add_cache,
`ifdef LRU_IDX_OUT_EN
   output logic [$clog2(WAYS)-1:0] lru_idx,
`endif
   output logic [WAYS-1:0]         lru_number
);

   logic [WAYS-1:0]            upd_pri;
   logic [WAYS-1:0]            touch;
   // older[i][j]: way i is older than way j (diagonal tied high)
   logic [WAYS-1:0][WAYS-1:0]  older;

   assign upd_pri = lru_update & (~lru_update + WAYS'(1));
   assign touch   = add_cache ? lru_number : upd_pri;

   for (genvar r = 0; r < WAYS; r++) begin : g_row
      assign older[r][r] = 1'b1;
      for (genvar c = 0; c < r; c++) begin : g_col
         logic q;

         lru_age_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .set   (touch[r]),
            .clr   (touch[c]),
            .q     (q)
         );

         assign older[c][r] = q;
         assign older[r][c] = ~q;
      end
   end

   for (genvar k = 0; k < WAYS; k++) begin : g_dec
      assign lru_number[k] = &older[k];
   end

`ifdef LRU_IDX_OUT_EN
   assign lru_idx = onehot_to_idx(lru_number);
`endif

endmodule

// File: tb/tb_lru_matrix8.sv
// Randomized self-checking bench for lru_matrix8 against an age-queue model.
module tb_lru_matrix8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] lru_update = '0;
   logic       add_cache = 1'b0;
   logic [7:0] lru_number;
`ifdef LRU_IDX_OUT_EN
   logic [2:0] lru_idx;
`endif

   int n_chk = 0;
   int n_err = 0;
   int m_ord[$];

   always #5 clk = ~clk;

   lru_matrix8 dut (
      .clk        (clk),
      .reset      (reset),
      .lru_update (lru_update),
      .add_cache  (add_cache),
`ifdef LRU_IDX_OUT_EN
      .lru_idx    (lru_idx),
`endif
      .lru_number (lru_number)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      m_ord = {7, 6, 5, 4, 3, 2, 1, 0};
   endfunction

   function automatic void m_touch(input int k);
      for (int i = 0; i < m_ord.size(); i++) begin
         if (m_ord[i] == k) begin
            m_ord.delete(i);
            break;
         end
      end
      m_ord.push_back(k);
   endfunction

   function automatic logic [7:0] m_lru();
      logic [7:0] one;
      one = 8'd1;
      return one << m_ord[0];
   endfunction

   task automatic check_out(input string tag);
      chk(tag, {24'd0, lru_number}, {24'd0, m_lru()});
      chk({tag, "_onehot"}, {31'd0, $onehot(lru_number)}, 32'd1);
`ifdef LRU_IDX_OUT_EN
      chk({tag, "_idx"}, {29'd0, lru_idx}, m_ord[0]);
`endif
   endtask

   task automatic step(input logic [7:0] u, input logic a);
      int k;
      lru_update = u;
      add_cache  = a;
      @(posedge clk);
      k = -1;
      if (a) k = m_ord[0];
      else begin
         for (int i = 7; i >= 0; i--) if (u[i]) k = i;
      end
      if (k >= 0) m_touch(k);
      #1;
      lru_update = '0;
      add_cache  = 1'b0;
   endtask

   initial begin
      m_reset();
      #12;
      reset = 1'b0;
      #1;
      check_out("reset");
      chk("reset_val", {24'd0, lru_number}, 32'h80);
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      chk("idle", {24'd0, lru_number}, 32'h80);

      step(8'h00, 1'b1);
      chk("fill1", {24'd0, lru_number}, 32'h40);
      step(8'h00, 1'b1);
      chk("fill2", {24'd0, lru_number}, 32'h20);
      step(8'h00, 1'b1);
      chk("fill3", {24'd0, lru_number}, 32'h10);

      step(8'h04, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b1);
      chk("seq3", {24'd0, lru_number}, 32'h02);

      step(8'h01, 1'b0);
      step(8'h02, 1'b0);
      step(8'h40, 1'b0);
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      chk("seq4", {24'd0, lru_number}, 32'h04);
      check_out("seq4_model");

      // order now 2,3,4,0,1,6,7,5: fill touches way 2 only
      step(8'h01, 1'b1);
      check_out("add_prio");
      chk("add_prio_val", {24'd0, lru_number}, 32'h08);
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      check_out("add_prio_way0");
      chk("add_prio_way0_val", {24'd0, lru_number}, 32'h01);

      step(8'h06, 1'b0);
      check_out("multi_hot");
      step(8'h02, 1'b0);
      check_out("newest_touch");

      #2;
      reset = 1'b1;
      #1;
      m_reset();
      chk("async_rst", {24'd0, lru_number}, 32'h80);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_out("post_rst");

      for (int n = 0; n < 400; n++) begin
         logic [7:0] u;
         logic       a;
         int         sel;
         sel = $urandom_range(0, 9);
         a   = ($urandom_range(0, 3) == 0);
         if (sel < 2)      u = 8'h00;
         else if (sel < 7) u = 8'd1 << $urandom_range(0, 7);
         else              u = 8'($urandom);
         step(u, a);
         check_out("rand");
         if ($urandom_range(0, 49) == 0) begin
            #2;
            reset = 1'b1;
            #1;
            m_reset();
            check_out("rand_rst");
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
